// File: rtl/issue_queue.sv
// Out-of-order issue queue feeding the PRF: wakeup on result broadcast, one select per cycle.
// Optional IQ_OLDEST_FIRST_EN adds an age matrix so select picks the oldest ready entry.
module issue_queue #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 6,
  parameter int PAY_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic [TAG_W-1:0]         disp_src0,
  input  logic [TAG_W-1:0]         disp_src1,
  input  logic                     disp_rdy0,
  input  logic                     disp_rdy1,
  input  logic [TAG_W-1:0]         disp_dst,
  input  logic [PAY_W-1:0]         disp_payload,
  input  logic                     wb_valid,
  input  logic [TAG_W-1:0]         wb_tag,
  output logic [TAG_W-1:0]         rd_addr0,
  output logic [TAG_W-1:0]         rd_addr1,
  output logic                     iss_valid,
  output logic [TAG_W-1:0]         iss_dst,
  output logic [PAY_W-1:0]         iss_payload,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0] valid, rdy0, rdy1;
  logic [TAG_W-1:0] src0 [DEPTH];
  logic [TAG_W-1:0] src1 [DEPTH];
  logic [TAG_W-1:0] dst  [DEPTH];
  logic [PAY_W-1:0] payload [DEPTH];

  logic [DEPTH-1:0] cand, pick;
  logic             sel_found, disp_fire, iss_fire;
  logic [IDX_W-1:0] sel_idx, free_idx;

  assign disp_ready = (occupancy != OCC_W'(DEPTH));
  assign disp_fire  = disp_valid & disp_ready & ~flush;
  assign iss_fire   = sel_found & ~flush;
  assign cand       = valid & rdy0 & rdy1;

`ifdef IQ_OLDEST_FIRST_EN
  // older[i][j] is set when entry i was dispatched before entry j
  logic [DEPTH-1:0] older [DEPTH];

  always_comb begin
    pick = cand;
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < DEPTH; j++)
        if (cand[j] && older[j][i]) pick[i] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
    end else begin
      if (iss_fire)
        for (int j = 0; j < DEPTH; j++) older[j][sel_idx] <= 1'b0;
      if (disp_fire) begin
        older[free_idx] <= '0;
        for (int j = 0; j < DEPTH; j++)
          older[j][free_idx] <= valid[j] && !(iss_fire && sel_idx == IDX_W'(j));
      end
    end
  end
`else
  assign pick = cand;
`endif

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    free_idx  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (pick[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
      if (!valid[i]) free_idx = IDX_W'(i);
    end
  end

  assign rd_addr0 = sel_found ? src0[sel_idx] : '0;
  assign rd_addr1 = sel_found ? src1[sel_idx] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid       <= '0;
      iss_valid   <= 1'b0;
      iss_dst     <= '0;
      iss_payload <= '0;
      occupancy   <= '0;
    end else if (flush) begin
      valid     <= '0;
      iss_valid <= 1'b0;
      occupancy <= '0;
    end else begin
      iss_valid <= sel_found;
      if (sel_found) begin
        iss_dst          <= dst[sel_idx];
        iss_payload      <= payload[sel_idx];
        valid[sel_idx]   <= 1'b0;
      end
      if (disp_fire) valid[free_idx] <= 1'b1;
      occupancy <= occupancy + OCC_W'(disp_fire) - OCC_W'(sel_found);
    end
  end

  // Readiness is only meaningful while valid, so the entry payload needs no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wb_valid && valid[i] && src0[i] == wb_tag) rdy0[i] <= 1'b1;
      if (wb_valid && valid[i] && src1[i] == wb_tag) rdy1[i] <= 1'b1;
    end
    if (disp_fire) begin
      src0[free_idx]    <= disp_src0;
      src1[free_idx]    <= disp_src1;
      rdy0[free_idx]    <= disp_rdy0 | (wb_valid && wb_tag == disp_src0);
      rdy1[free_idx]    <= disp_rdy1 | (wb_valid && wb_tag == disp_src1);
      dst[free_idx]     <= disp_dst;
      payload[free_idx] <= disp_payload;
    end
  end

endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- Out-of-order issue queue (reservation station) sitting directly upstream of the physical register file.
- Holds dispatched, renamed instructions until both physical source operands are ready; wakes them on result-tag broadcasts; selects one per cycle.
- Drives the PRF read addresses combinationally in the select cycle. Issued destination tag and payload are registered so they arrive at execute in the same cycle as the PRF's registered read data.

Parameters:
- DEPTH, 8, number of queue entries (power of 2, 2..16)
- TAG_W, 6, physical register tag width (64 PRF entries)
- PAY_W, 32, opaque payload width (opcode, immediate, ROB id), passed through unchanged

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous active-high reset
- flush  in  1  synchronous clear of all entries (mispredict recovery)
- disp_valid  in  1  dispatch request
- disp_ready  out  1  queue can accept a dispatch this cycle
- disp_src0, disp_src1  in  TAG_W each  physical source tags
- disp_rdy0, disp_rdy1  in  1 each  source already ready at rename
- disp_dst  in  TAG_W  physical destination tag
- disp_payload  in  PAY_W  payload
- wb_valid  in  1  result broadcast (same signal as PRF write enable)
- wb_tag  in  TAG_W  broadcast tag (same as PRF write address)
- rd_addr0, rd_addr1  out  TAG_W each  combinational PRF read addresses of the selected entry
- iss_valid  out  1  registered: instruction issued last cycle
- iss_dst  out  TAG_W  registered destination tag
- iss_payload  out  PAY_W  registered payload
- occupancy  out  $clog2(DEPTH)+1  registered count of valid entries

Behaviour:
- Entry state: valid, src0, rdy0, src1, rdy1, dst, payload.
- Reset (async on rst): all valid cleared; iss_valid=0, iss_dst=0, iss_payload=0, occupancy=0. rd_addr0/1=0 when no entry is selected.
- disp_ready = (occupancy != DEPTH). Based on start-of-cycle state; a slot freed by issue in the same cycle is not reusable until the next cycle.
- Dispatch accepted when disp_valid & disp_ready. Written into the lowest-index invalid entry.
- Dispatch/broadcast bypass: if wb_valid and wb_tag equals disp_srcN in the same cycle, rdyN is stored as 1.
- Wakeup: every valid entry with srcN==wb_tag while wb_valid sets rdyN at the clock edge. A woken entry is eligible to be selected the following cycle, not the same cycle.
- Select (cycle N): candidates are valid & rdy0 & rdy1. Picks the lowest index among candidates.
  - rd_addr0/1 = selected src0/src1 during cycle N.
  - At edge N: entry invalidated; iss_valid=1, iss_dst and iss_payload loaded.
  - Cycle N+1: iss_* valid, aligned with PRF dout0/dout1.
  - No candidate: iss_valid=0 next cycle; iss_dst/iss_payload hold their previous values.
- Dispatch and issue may occur in the same cycle. Occupancy adds +1 for dispatch and -1 for issue, both in the same cycle.
- flush: at the edge all entries invalid, occupancy=0, iss_valid=0. A dispatch in the flush cycle is dropped. A wakeup in the flush cycle is ignored.
- No backpressure from execute: the issued instruction is always consumed.
- Two sources carrying the same tag are both woken by one broadcast.

Optional Feature:
- IQ_OLDEST_FIRST_EN defined: per-entry age tracking, an age matrix or age counters of width $clog2(DEPTH). Select picks the oldest ready entry, i.e. the earliest dispatched. The age order is updated on dispatch, issue and flush.
- Undefined: lowest-index-first select as above. No age state is instantiated.

Test Plan:
- Reset mid-operation: fill 3 entries, assert rst asynchronously between edges -> occupancy=0, iss_valid=0 immediately; disp_ready=1.
- Ready-at-dispatch: dispatch src0=5,rdy0=1, src1=9,rdy1=1, dst=20 in cycle 0 -> cycle 1 rd_addr0=5, rd_addr1=9; cycle 2 iss_valid=1, iss_dst=20.
- Wakeup: dispatch src0=7 (not ready), src1=3 (ready); wb_valid, wb_tag=7 in cycle 4 -> rd_addr0=7 in cycle 5; iss_valid=1 in cycle 6. Also dispatch with wb_tag==disp_src0 in the same cycle -> issues as if ready at dispatch.
- Full: dispatch 8 never-ready entries -> disp_ready=0, occupancy=8. A further disp_valid is not accepted. Wake one -> issued, then disp_ready=1 the cycle after issue.
- Priority: entries 2 and 5 both become ready in the same cycle -> entry 2 issues first, entry 5 the next cycle. With IQ_OLDEST_FIRST_EN, if 5 was dispatched first -> 5 issues first.
- Flush with simultaneous dispatch and wakeup: 4 entries, flush=1, disp_valid=1, wb_valid=1 -> next cycle occupancy=0, iss_valid=0, no later issue of any of them.
